// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-requester (CPU / DMA) round-robin arbiter in front of a single
//            memory/IO port. One transaction at a time: grant, hold strobes
//            until mem_ready_i, pulse the owner's ready, back to IDLE. A wait
//            counter aborts stuck transactions and sets a sticky error flag.
// Ports    : clk_i, reset_ni (async, active-low)
//            cpu_req_i/we_i/addr_i/wdata_i -> cpu_ready_o/cpu_rdata_o
//            dma_req_i/we_i/addr_i/wdata_i -> dma_ready_o/dma_rdata_o
//            mem_rd_o/mem_wr_o/mem_addr_o/mem_wdata_o <- mem_ready_i/mem_rdata_i
//            grant_o (00 none, 01 CPU, 10 DMA), timeout_err_o, state_out_o
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_ready_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic        dma_ready_o,
  output logic [31:0] dma_rdata_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  grant_o,
  output logic        timeout_err_o,
  output logic [1:0]  state_out_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CPU  = 2'b01,
    S_DMA  = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic          last_dma_q, last_dma_d;   // 1: DMA was granted last
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic          cpu_ready_q, cpu_ready_d, dma_ready_q, dma_ready_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_inc;
  logic          cpu_wins;

  assign cnt_inc  = cnt_q + 1'b1;
  // CPU wins when alone, or on a tie when DMA owned the port last.
  assign cpu_wins = cpu_req_i && (!dma_req_i || last_dma_q);

  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cpu_wins) begin
          state_d    = S_CPU;
          last_dma_d = 1'b0;
          rd_d       = !cpu_we_i;
          wr_d       = cpu_we_i;
          addr_d     = cpu_addr_i;
          wdata_d    = cpu_wdata_i;
        end else if (dma_req_i) begin
          state_d    = S_DMA;
          last_dma_d = 1'b1;
          rd_d       = !dma_we_i;
          wr_d       = dma_we_i;
          addr_d     = dma_addr_i;
          wdata_d    = dma_wdata_i;
        end
      end

      S_CPU, S_DMA: begin
        if (mem_ready_i) begin
          // Normal completion beats a timeout landing on the same edge.
          state_d = S_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (state_q == S_CPU) begin
            cpu_ready_d = 1'b1;
            if (rd_q) cpu_rdata_d = mem_rdata_i;
          end else begin
            dma_ready_d = 1'b1;
            if (rd_q) dma_rdata_d = mem_rdata_i;
          end
        end else if (cnt_inc == C_TIMEOUT) begin
          state_d = S_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          if (state_q == S_CPU) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = 32'h0000_0000;
          end else begin
            dma_ready_d = 1'b1;
            dma_rdata_d = 32'h0000_0000;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      last_dma_q  <= 1'b1;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= 32'h0;
      dma_rdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      err_q       <= err_d;
    end
  end

  assign cpu_ready_o   = cpu_ready_q;
  assign dma_ready_o   = dma_ready_q;
  assign cpu_rdata_o   = cpu_rdata_q;
  assign dma_rdata_o   = dma_rdata_q;
  assign mem_rd_o      = rd_q;
  assign mem_wr_o      = wr_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign timeout_err_o = err_q;
  assign state_out_o   = state_q;
  assign grant_o       = (state_q == S_CPU) ? 2'b01 :
                         (state_q == S_DMA) ? 2'b10 : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter (TIMEOUT = 4).
//            Inputs are driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_ready, dma_ready, mem_rd, mem_wr, timeout_err;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [1:0]  grant, state_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_ready_o  (cpu_ready),
    .cpu_rdata_o  (cpu_rdata),
    .dma_req_i    (dma_req),
    .dma_we_i     (dma_we),
    .dma_addr_i   (dma_addr),
    .dma_wdata_i  (dma_wdata),
    .dma_ready_o  (dma_ready),
    .dma_rdata_o  (dma_rdata),
    .mem_rd_o     (mem_rd),
    .mem_wr_o     (mem_wr),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ready_i  (mem_ready),
    .mem_rdata_i  (mem_rdata),
    .grant_o      (grant),
    .timeout_err_o(timeout_err),
    .state_out_o  (state_out)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    step(2);
    reset_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    #1;
    tests++;
    if ({state_out, grant, mem_rd, mem_wr, cpu_ready, dma_ready, timeout_err} !== 9'b0) begin
      fails++;
      $display("FAIL reset_ctrl: state=%b grant=%b rd=%b wr=%b crdy=%b drdy=%b err=%b, want all 0",
               state_out, grant, mem_rd, mem_wr, cpu_ready, dma_ready, timeout_err);
    end
    tests++;
    if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h, want 0",
               mem_addr, mem_wdata, cpu_rdata, dma_rdata);
    end
    step(2);
    reset_n = 1;
  endtask

  // CPU read, mem_ready sampled on the 3rd edge after grant.
  task automatic test_cpu_read();
    int rd_cycles = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0004;
    step(1);
    tests++;
    if (grant !== 2'b01 || state_out !== 2'b01 || mem_addr !== 32'h4 || mem_wr !== 1'b0) begin
      fails++;
      $display("FAIL cpu_read_grant: grant=%b state=%b addr=%h wr=%b, want 01 01 4 0",
               grant, state_out, mem_addr, mem_wr);
    end
    for (int k = 1; k <= 3; k++) begin
      if (mem_rd === 1'b1 && grant === 2'b01) rd_cycles++;
      if (k == 3) begin mem_ready = 1; mem_rdata = 32'h1234_5678; end
      step(1);
    end
    mem_ready = 0; cpu_req = 0;
    tests++;
    if (rd_cycles != 3 || mem_rd !== 1'b0) begin
      fails++;
      $display("FAIL cpu_read_strobe: rd_cycles=%0d rd_after=%b, want 3 and 0", rd_cycles, mem_rd);
    end
    tests++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h1234_5678 || grant !== 2'b00 ||
        state_out !== 2'b00 || dma_ready !== 1'b0) begin
      fails++;
      $display("FAIL cpu_read_done: crdy=%b rdata=%h grant=%b state=%b drdy=%b, want 1 12345678 00 00 0",
               cpu_ready, cpu_rdata, grant, state_out, dma_ready);
    end
    step(1);
    tests++;
    if (cpu_ready !== 1'b0) begin
      fails++;
      $display("FAIL cpu_read_pulse: crdy=%b one cycle later, want 0", cpu_ready);
    end
  endtask

  // Simultaneous requests from reset: CPU first, DMA after one IDLE cycle.
  task automatic test_tie();
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hAAAA_0001;
    dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    step(1);
    tests++;
    if (grant !== 2'b01 || mem_wr !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hAAAA_0001) begin
      fails++;
      $display("FAIL tie_cpu_first: grant=%b wr=%b addr=%h wdata=%h, want 01 1 10 aaaa0001",
               grant, mem_wr, mem_addr, mem_wdata);
    end
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    step(1);
    mem_ready = 0; cpu_req = 0;
    tests++;
    if (state_out !== 2'b00 || cpu_ready !== 1'b1 || cpu_rdata !== 32'h0 || dma_ready !== 1'b0) begin
      fails++;
      $display("FAIL tie_idle_gap: state=%b crdy=%b crdata=%h drdy=%b, want 00 1 0 0",
               state_out, cpu_ready, cpu_rdata, dma_ready);
    end
    step(1);
    tests++;
    if (grant !== 2'b10 || mem_rd !== 1'b1 || mem_addr !== 32'h20 || cpu_ready !== 1'b0) begin
      fails++;
      $display("FAIL tie_dma_second: grant=%b rd=%b addr=%h crdy=%b, want 10 1 20 0",
               grant, mem_rd, mem_addr, cpu_ready);
    end
    mem_ready = 1; mem_rdata = 32'h0000_AAAA;
    step(1);
    mem_ready = 0; dma_req = 0;
    tests++;
    if (dma_ready !== 1'b1 || dma_rdata !== 32'h0000_AAAA || cpu_ready !== 1'b0) begin
      fails++;
      $display("FAIL tie_dma_done: drdy=%b drdata=%h crdy=%b, want 1 0000aaaa 0",
               dma_ready, dma_rdata, cpu_ready);
    end
    step(1);
  endtask

  // DMA write with mem_ready never asserted.
  task automatic test_timeout();
    int wr_cycles = 0;
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'hCAFE_F00D;
    step(1);
    tests++;
    if (grant !== 2'b10 || mem_wr !== 1'b1 || mem_wdata !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL timeout_grant: grant=%b wr=%b wdata=%h, want 10 1 cafef00d",
               grant, mem_wr, mem_wdata);
    end
    for (int k = 0; k < 20; k++) begin
      if (mem_wr !== 1'b1) break;
      wr_cycles++;
      step(1);
    end
    dma_req = 0;
    tests++;
    if (wr_cycles != 4 || dma_ready !== 1'b1 || dma_rdata !== 32'h0 ||
        timeout_err !== 1'b1 || state_out !== 2'b00 || cpu_ready !== 1'b0) begin
      fails++;
      $display("FAIL timeout_abort: wr_cycles=%0d drdy=%b drdata=%h err=%b state=%b crdy=%b, want 4 1 0 1 00 0",
               wr_cycles, dma_ready, dma_rdata, timeout_err, state_out, cpu_ready);
    end
    step(3);
    tests++;
    if (timeout_err !== 1'b1 || dma_ready !== 1'b0) begin
      fails++;
      $display("FAIL timeout_sticky: err=%b drdy=%b, want 1 0", timeout_err, dma_ready);
    end
    do_reset();
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: err=%b after reset, want 0", timeout_err);
    end
  endtask

  // mem_ready lands on the same edge the counter reaches TIMEOUT.
  task automatic test_ready_at_timeout();
    int rd_cycles = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
    step(1);
    for (int k = 1; k <= 4; k++) begin
      if (mem_rd === 1'b1) rd_cycles++;
      if (k == 4) begin mem_ready = 1; mem_rdata = 32'h0BAD_CAFE; end
      step(1);
    end
    mem_ready = 0; cpu_req = 0;
    tests++;
    if (rd_cycles != 4 || cpu_ready !== 1'b1 || cpu_rdata !== 32'h0BAD_CAFE ||
        timeout_err !== 1'b0 || mem_rd !== 1'b0) begin
      fails++;
      $display("FAIL ready_at_timeout: rd_cycles=%0d crdy=%b rdata=%h err=%b rd=%b, want 4 1 0badcafe 0 0",
               rd_cycles, cpu_ready, cpu_rdata, timeout_err, mem_rd);
    end
    step(1);
  endtask

  // Reset asserted mid-write, between clock edges.
  task automatic test_reset_mid();
    int pulses = 0;
    dma_req = 1; dma_we = 1; dma_addr = 32'h50; dma_wdata = 32'h1;
    step(1);
    tests++;
    if (mem_wr !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: wr=%b, want 1", mem_wr);
    end
    #2 reset_n = 0;
    #1;
    tests++;
    if (mem_wr !== 1'b0 || state_out !== 2'b00 || grant !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_async: wr=%b state=%b grant=%b, want 0 00 00", mem_wr, state_out, grant);
    end
    dma_req = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) reset_n = 1;
      step(1);
      if (dma_ready !== 1'b0 || cpu_ready !== 1'b0) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL reset_mid_no_ready: ready pulses=%0d, want 0", pulses);
    end
  endtask

  // cpu_req dropped right after grant; also mem_ready in IDLE is ignored.
  task automatic test_req_drop();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'hC;
    step(1);
    cpu_req = 0;
    step(1);
    tests++;
    if (grant !== 2'b01 || mem_rd !== 1'b1 || mem_addr !== 32'hC) begin
      fails++;
      $display("FAIL req_drop_hold: grant=%b rd=%b addr=%h, want 01 1 c", grant, mem_rd, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h0000_0055;
    step(1);
    tests++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h55) begin
      fails++;
      $display("FAIL req_drop_done: crdy=%b rdata=%h, want 1 00000055", cpu_ready, cpu_rdata);
    end
    mem_rdata = 32'h0000_0077;
    step(1);
    mem_ready = 0;
    tests++;
    if (state_out !== 2'b00 || cpu_ready !== 1'b0 || dma_ready !== 1'b0 || cpu_rdata !== 32'h55) begin
      fails++;
      $display("FAIL idle_ready_ignored: state=%b crdy=%b drdy=%b rdata=%h, want 00 0 0 00000055",
               state_out, cpu_ready, dma_ready, cpu_rdata);
    end
  endtask

  initial begin
    test_reset();
    step(1);
    test_cpu_read();
    test_tie();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid();
    test_req_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
